// File: rtl/mips_core_pkg.sv
// Shared core types: thread id, default slice sizing and packed stage payloads.
// Each payload struct packs to exactly MC_DATA_W bits for the elastic slice.
package mips_core_pkg;

    localparam int MC_DATA_W      = 96;
    localparam int MC_TID_W       = 1;
    localparam int MC_NUM_THREADS = 2 ** MC_TID_W;

    typedef logic [MC_TID_W-1:0] tid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } i2d_t;

    typedef struct packed {
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [10:0] ctrl;
    } d2e_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic [26:0] ctrl;
    } e2m_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [31:0] mem_val;
        logic [4:0]  rd;
        logic [26:0] ctrl;
    } m2w_t;

    function automatic logic [1:0] sat_cnt3(input logic a,
                                            input logic b,
                                            input logic c);
        logic [1:0] s;
        s = {1'b0, a} + {1'b0, b} + {1'b0, c};
        return (s > 2'd2) ? 2'd2 : s;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One elastic-slice entry {valid, tid, data}.
// Load wins over clear; a held entry is also dropped when its thread is killed.
module pipe_slot
    import mips_core_pkg::*;
#(
    parameter int DATA_W      = MC_DATA_W,
    parameter int TID_W       = MC_TID_W,
    parameter int NUM_THREADS = MC_NUM_THREADS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_load,
    input  logic                   i_clear,
    input  logic [NUM_THREADS-1:0] i_kill_mask,
    input  logic [TID_W-1:0]       i_tid,
    input  logic [DATA_W-1:0]      i_data,
    output logic                   o_valid,
    output logic [TID_W-1:0]       o_tid,
    output logic [DATA_W-1:0]      o_data
);

    logic              r_valid;
    logic [TID_W-1:0]  r_tid;
    logic [DATA_W-1:0] r_data;
    logic              w_valid_nxt;

    assign w_valid_nxt = i_load
                       | (r_valid & ~i_clear & ~i_kill_mask[r_tid]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_tid   <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (i_load) begin
                r_tid  <= i_tid;
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_tid   = r_tid;
    assign o_data  = r_data;

endmodule

// File: rtl/mt_elastic_pipe_reg.sv
// Thread-aware elastic pipeline register: head entry H plus optional skid entry S,
// valid/ready handshake, stall freeze and per-thread selective flush.
module mt_elastic_pipe_reg
    import mips_core_pkg::*;
#(
    parameter int DATA_W      = MC_DATA_W,
    parameter int TID_W       = MC_TID_W,
    parameter int NUM_THREADS = MC_NUM_THREADS,
    parameter int SKID        = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic [NUM_THREADS-1:0] flush_mask,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic [TID_W-1:0]       i_tid,
    input  logic [DATA_W-1:0]      i_data,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [TID_W-1:0]       o_tid,
    output logic [DATA_W-1:0]      o_data,
    output logic [1:0]             occupancy,
    output logic [1:0]             killed_cnt
);

    logic              w_h_valid, w_s_valid;
    logic [TID_W-1:0]  w_h_tid, w_s_tid;
    logic [DATA_W-1:0] w_h_data, w_s_data;
    logic              w_h_kill, w_s_kill, w_in_kill;
    logic              w_space;
    logic              w_in_fire, w_out_fire;
    logic              w_h_live, w_s_live, w_in_live;
    logic              w_h_load, w_s_load;
    logic [TID_W-1:0]  w_h_tid_in;
    logic [DATA_W-1:0] w_h_data_in;
    logic [1:0]        r_killed_cnt;

    assign w_space   = (SKID != 0) ? ~w_s_valid : (~w_h_valid | o_ready);
    assign i_ready   = w_space & ~stall & rst_n;
    assign o_valid   = w_h_valid & ~stall & ~flush_mask[w_h_tid];
    assign w_in_fire  = i_valid & i_ready;
    assign w_out_fire = o_valid & o_ready;

    assign w_h_kill  = w_h_valid & flush_mask[w_h_tid];
    assign w_s_kill  = w_s_valid & flush_mask[w_s_tid];
    assign w_in_kill = w_in_fire & flush_mask[i_tid];

    // Survivors in FIFO order (H, S, incoming) compact toward H.
    assign w_h_live  = w_h_valid & ~w_h_kill & ~w_out_fire;
    assign w_s_live  = w_s_valid & ~w_s_kill;
    assign w_in_live = w_in_fire & ~w_in_kill;

    assign w_h_load    = ~w_h_live & (w_s_live | w_in_live);
    assign w_h_tid_in  = w_s_live ? w_s_tid : i_tid;
    assign w_h_data_in = w_s_live ? w_s_data : i_data;
    assign w_s_load    = w_in_live & (w_h_live | w_s_live);

    pipe_slot #(
        .DATA_W      (DATA_W),
        .TID_W       (TID_W),
        .NUM_THREADS (NUM_THREADS)
    ) u_head (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_h_load),
        .i_clear     (~w_h_live),
        .i_kill_mask (flush_mask),
        .i_tid       (w_h_tid_in),
        .i_data      (w_h_data_in),
        .o_valid     (w_h_valid),
        .o_tid       (w_h_tid),
        .o_data      (w_h_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .DATA_W      (DATA_W),
                .TID_W       (TID_W),
                .NUM_THREADS (NUM_THREADS)
            ) u_skid (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_load      (w_s_load),
                .i_clear     (~(w_h_live & w_s_live)),
                .i_kill_mask (flush_mask),
                .i_tid       (i_tid),
                .i_data      (i_data),
                .o_valid     (w_s_valid),
                .o_tid       (w_s_tid),
                .o_data      (w_s_data)
            );
        end else begin : g_noskid
            assign w_s_valid = 1'b0;
            assign w_s_tid   = '0;
            assign w_s_data  = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_killed_cnt <= 2'd0;
        end else begin
            r_killed_cnt <= sat_cnt3(w_h_kill, w_s_kill, w_in_kill);
        end
    end

    assign killed_cnt = r_killed_cnt;
    assign occupancy  = {1'b0, w_h_valid} + {1'b0, w_s_valid};
    assign o_tid      = w_h_tid;
    assign o_data     = w_h_data;

endmodule
